// File: rtl/mig_app_resp.sv
// Stand-in for the MIG 7-series user interface (4:1 mode, 128-bit data, BL8) backed by on-chip RAM.
// Define MIG_RESP_REFRESH_EN to add a periodic 8-in-256-cycle refresh stall.
module mig_app_resp #(
  parameter int MEM_AW       = 6,
  parameter int RD_LAT       = 4,
  parameter int CALIB_CYCLES = 32
) (
  input  logic         ui_clk,
  input  logic         sys_rst_n,
  output logic         init_calib_complete,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         proto_err
);

  localparam int          WORDS     = 1 << MEM_AW;
  localparam logic [2:0]  CMD_WRITE = 3'b000;
  localparam logic [2:0]  CMD_READ  = 3'b001;
  localparam logic [2:0]  Q_FULL    = 3'd4;
  localparam logic [15:0] CALIB_TGT = 16'(CALIB_CYCLES);

  typedef logic [MEM_AW-1:0] idx_t;

  typedef struct packed {
    logic [2:0] cmd;
    idx_t       idx;
  } cmd_ent_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  mask;
  } wd_ent_t;

  logic [15:0]       calib_cnt_q, calib_cnt_d;
  logic              calib_done_q, calib_done_d;
  logic [1:0]        cq_wp_q, cq_wp_d, cq_rp_q, cq_rp_d;
  logic [2:0]        cq_cnt_q, cq_cnt_d;
  logic [1:0]        wq_wp_q, wq_wp_d, wq_rp_q, wq_rp_d;
  logic [2:0]        wq_cnt_q, wq_cnt_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic              rd_valid_q, rd_valid_d;
  logic [127:0]      rd_data_q, rd_data_d;
  logic              app_rdy_q, app_rdy_d;
  logic              wdf_rdy_q, wdf_rdy_d;
  logic              proto_err_q, proto_err_d;
  logic              hold_q, hold_d;
  logic [2:0]        hold_cmd_q, hold_cmd_d;

  cmd_ent_t     cq_mem [4];
  wd_ent_t      wq_mem [4];
  logic [127:0] mem [WORDS];
  logic [127:0] pipe_data_q [RD_LAT];

  logic     push_cmd, push_wd;
  logic     exec_go, exec_wr, exec_rd, exec_bad;
  cmd_ent_t head_cmd;
  wd_ent_t  head_wd;
  logic     refresh_stall, refresh_stall_nxt;
  logic     unused_addr_bits;

  assign unused_addr_bits = ^{app_addr[27:MEM_AW+3], app_addr[2:0]};

`ifdef MIG_RESP_REFRESH_EN
  logic [7:0] ref_cnt_q, ref_cnt_d;

  // Counter holds at 0 until calibration completes, so the first stall lands 248 cycles later.
  always_comb ref_cnt_d = calib_done_q ? ref_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge ui_clk) begin
    if (!sys_rst_n) ref_cnt_q <= '0;
    else            ref_cnt_q <= ref_cnt_d;
  end

  assign refresh_stall     = calib_done_q && (&ref_cnt_q[7:3]);
  assign refresh_stall_nxt = calib_done_d && (&ref_cnt_d[7:3]);
`else
  assign refresh_stall     = 1'b0;
  assign refresh_stall_nxt = 1'b0;
`endif

  assign head_cmd = cq_mem[cq_rp_q];
  assign head_wd  = wq_mem[wq_rp_q];

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave a latch behind.
    calib_cnt_d  = calib_cnt_q;
    calib_done_d = calib_done_q;
    if (!calib_done_q) begin
      calib_cnt_d  = calib_cnt_q + 16'd1;
      calib_done_d = (calib_cnt_d == CALIB_TGT);
    end

    push_cmd = app_en && app_rdy_q;
    push_wd  = app_wdf_wren && wdf_rdy_q;

    exec_go  = (cq_cnt_q != 3'd0) && !refresh_stall &&
               ((head_cmd.cmd != CMD_WRITE) || (wq_cnt_q != 3'd0));
    exec_wr  = exec_go && (head_cmd.cmd == CMD_WRITE);
    exec_rd  = exec_go && (head_cmd.cmd == CMD_READ);
    exec_bad = exec_go && !exec_wr && !exec_rd;

    cq_wp_d = push_cmd ? cq_wp_q + 2'd1 : cq_wp_q;
    cq_rp_d = exec_go  ? cq_rp_q + 2'd1 : cq_rp_q;
    unique case ({push_cmd, exec_go})
      2'b10:   cq_cnt_d = cq_cnt_q + 3'd1;
      2'b01:   cq_cnt_d = cq_cnt_q - 3'd1;
      default: cq_cnt_d = cq_cnt_q;
    endcase

    wq_wp_d = push_wd ? wq_wp_q + 2'd1 : wq_wp_q;
    wq_rp_d = exec_wr ? wq_rp_q + 2'd1 : wq_rp_q;
    unique case ({push_wd, exec_wr})
      2'b10:   wq_cnt_d = wq_cnt_q + 3'd1;
      2'b01:   wq_cnt_d = wq_cnt_q - 3'd1;
      default: wq_cnt_d = wq_cnt_q;
    endcase

    pipe_vld_d[0] = exec_rd;
    for (int i = 1; i < RD_LAT; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
    rd_valid_d = pipe_vld_q[RD_LAT-1];
    rd_data_d  = pipe_vld_q[RD_LAT-1] ? pipe_data_q[RD_LAT-1] : rd_data_q;

    // Ready flags are registered, so they are derived from next-cycle occupancy.
    app_rdy_d = calib_done_d && (cq_cnt_d != Q_FULL) && !refresh_stall_nxt;
    wdf_rdy_d = calib_done_d && (wq_cnt_d != Q_FULL);

    hold_d      = app_en && !app_rdy_q;
    hold_cmd_d  = app_cmd;
    proto_err_d = proto_err_q
                | (app_wdf_wren != app_wdf_end)
                | (app_wdf_wren && !wdf_rdy_q)
                | (hold_q && app_en && (app_cmd != hold_cmd_q))
                | exec_bad;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ui_clk) begin
    if (!sys_rst_n) begin
      calib_cnt_q  <= '0;
      calib_done_q <= 1'b0;
      cq_wp_q      <= '0;
      cq_rp_q      <= '0;
      cq_cnt_q     <= '0;
      wq_wp_q      <= '0;
      wq_rp_q      <= '0;
      wq_cnt_q     <= '0;
      pipe_vld_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      app_rdy_q    <= 1'b0;
      wdf_rdy_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      hold_q       <= 1'b0;
      hold_cmd_q   <= '0;
    end else begin
      calib_cnt_q  <= calib_cnt_d;
      calib_done_q <= calib_done_d;
      cq_wp_q      <= cq_wp_d;
      cq_rp_q      <= cq_rp_d;
      cq_cnt_q     <= cq_cnt_d;
      wq_wp_q      <= wq_wp_d;
      wq_rp_q      <= wq_rp_d;
      wq_cnt_q     <= wq_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      app_rdy_q    <= app_rdy_d;
      wdf_rdy_q    <= wdf_rdy_d;
      proto_err_q  <= proto_err_d;
      hold_q       <= hold_d;
      hold_cmd_q   <= hold_cmd_d;
    end
  end

  // NOTE: storage arrays are left out of reset; pointers, counts and valid bits make stale contents unobservable.
  always_ff @(posedge ui_clk) begin
    if (push_cmd) cq_mem[cq_wp_q] <= '{cmd: app_cmd, idx: app_addr[MEM_AW+2:3]};
    if (push_wd)  wq_mem[wq_wp_q] <= '{data: app_wdf_data, mask: app_wdf_mask};
    if (sys_rst_n && exec_wr) begin
      for (int b = 0; b < 16; b++) begin
        if (!head_wd.mask[b]) mem[head_cmd.idx][8*b +: 8] <= head_wd.data[8*b +: 8];
      end
    end
    pipe_data_q[0] <= mem[head_cmd.idx];
    for (int i = 1; i < RD_LAT; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  assign init_calib_complete = calib_done_q;
  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = wdf_rdy_q;
  assign app_rd_data         = rd_data_q;
  assign app_rd_data_valid   = rd_valid_q;
  assign proto_err           = proto_err_q;

endmodule
